// File: rtl/plab5_mcore_mem_copy_engine_pkg.sv
// rtl/plab5_mcore_mem_copy_engine_pkg.sv - memory message type codes, field widths and copy FSM states
package plab5_mcore_mem_copy_engine_pkg;

    localparam logic [2:0] c_mem_type_read       = 3'd0;
    localparam logic [2:0] c_mem_type_write      = 3'd1;
    localparam logic [2:0] c_mem_type_write_init = 3'd2;
    localparam logic [2:0] c_mem_type_amo_add    = 3'd3;
    localparam logic [2:0] c_mem_type_amo_and    = 3'd4;
    localparam logic [2:0] c_mem_type_amo_or     = 3'd5;

    localparam int c_mem_type_nbits = 3;
    localparam int c_mem_len_nbits  = 2;

    // Request control is type, opaque, addr, len from MSB to LSB
    function automatic int req_cnbits(input int opaque_nbits, input int addr_nbits);
        return c_mem_type_nbits + opaque_nbits + addr_nbits + c_mem_len_nbits;
    endfunction

    // Response control is type, opaque, len from MSB to LSB
    function automatic int resp_cnbits(input int opaque_nbits);
        return c_mem_type_nbits + opaque_nbits + c_mem_len_nbits;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } copy_state_e;

endpackage

// File: rtl/plab5_mcore_mem_copy_engine_msg.sv
// rtl/plab5_mcore_mem_copy_engine_msg.sv - memory request control pack and response control unpack
module plab5_mcore_mem_copy_engine_req_pack
    import plab5_mcore_mem_copy_engine_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    localparam int c_req_cnbits  = req_cnbits(p_opaque_nbits, p_addr_nbits)
) (
    input  logic [2:0]                msg_type,
    input  logic [p_opaque_nbits-1:0] opaque,
    input  logic [p_addr_nbits-1:0]   addr,
    input  logic [1:0]                len,
    output logic [c_req_cnbits-1:0]   control
);

    assign control = {msg_type, opaque, addr, len};

endmodule

module plab5_mcore_mem_copy_engine_resp_unpack
    import plab5_mcore_mem_copy_engine_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    localparam int c_resp_cnbits = resp_cnbits(p_opaque_nbits)
) (
    input  logic [c_resp_cnbits-1:0]  control,
    output logic [2:0]                msg_type,
    output logic [p_opaque_nbits-1:0] opaque,
    output logic [1:0]                len
);

    assign {msg_type, opaque, len} = control;

endmodule

// File: rtl/plab5_mcore_mem_copy_engine.sv
// rtl/plab5_mcore_mem_copy_engine.sv - block copy engine issuing one read/write memory request at a time
module plab5_mcore_mem_copy_engine
    import plab5_mcore_mem_copy_engine_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_cnt_nbits    = 16,
    localparam int c_req_cnbits  = req_cnbits(p_opaque_nbits, p_addr_nbits),
    localparam int c_resp_cnbits = resp_cnbits(p_opaque_nbits)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_val,
    output logic                     cmd_rdy,
    input  logic [p_addr_nbits-1:0]  cmd_src,
    input  logic [p_addr_nbits-1:0]  cmd_dst,
    input  logic [p_cnt_nbits-1:0]   cmd_nwords,
    input  logic                     cmd_domain,
    output logic                     done_val,
    input  logic                     done_rdy,
    output logic [p_cnt_nbits-1:0]   done_count,
    output logic                     done_err,
    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    output logic [c_req_cnbits-1:0]  memreq_control,
    output logic [p_data_nbits-1:0]  memreq_data,
    output logic                     memreq_domain,
    input  logic                     memresp_val,
    output logic                     memresp_rdy,
    input  logic [c_resp_cnbits-1:0] memresp_control,
    input  logic [p_data_nbits-1:0]  memresp_data,
    input  logic                     memresp_domain
);

    copy_state_e state, state_next;

    logic [p_addr_nbits-1:0]   src_addr;
    logic [p_addr_nbits-1:0]   dst_addr;
    logic [p_cnt_nbits-1:0]    nwords;
    logic [p_cnt_nbits-1:0]    idx;
    logic [p_cnt_nbits-1:0]    idx_inc;
    logic                      domain;
    logic                      err;
    logic [p_data_nbits-1:0]   data_buf;

    logic [2:0]                req_type;
    logic [p_addr_nbits-1:0]   req_addr;
    logic [p_addr_nbits-1:0]   word_off;
    logic [2:0]                resp_type;
    logic [p_opaque_nbits-1:0] resp_opaque;
    logic [1:0]                resp_len;
    logic                      unused_resp;

    // Word index is p_cnt_nbits wide, so a full-range count never overflows it
    assign idx_inc  = idx + 1'b1;
    assign word_off = p_addr_nbits'({idx, 2'b00});

    // Address arithmetic wraps silently modulo 2^p_addr_nbits
    assign req_type      = (state == ST_WR_REQ) ? c_mem_type_write : c_mem_type_read;
    assign req_addr      = ((state == ST_WR_REQ) ? dst_addr : src_addr) + word_off;
    assign memreq_data   = (state == ST_WR_REQ) ? data_buf : '0;
    assign memreq_domain = domain;

    assign done_count = idx;
    assign done_err   = err;

    plab5_mcore_mem_copy_engine_req_pack #(
        .p_opaque_nbits (p_opaque_nbits),
        .p_addr_nbits   (p_addr_nbits)
    ) u_req_pack (
        .msg_type (req_type),
        .opaque   (idx[p_opaque_nbits-1:0]),
        .addr     (req_addr),
        .len      (2'b00),
        .control  (memreq_control)
    );

    plab5_mcore_mem_copy_engine_resp_unpack #(
        .p_opaque_nbits (p_opaque_nbits)
    ) u_resp_unpack (
        .control  (memresp_control),
        .msg_type (resp_type),
        .opaque   (resp_opaque),
        .len      (resp_len)
    );

    // Response domain is deliberately ignored: denied data is copied as returned
    assign unused_resp = ^{memresp_domain, resp_opaque, resp_len};

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next  = state;
        cmd_rdy     = 1'b0;
        done_val    = 1'b0;
        memreq_val  = 1'b0;
        memresp_rdy = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_val) state_next = (cmd_nwords == '0) ? ST_DONE : ST_RD_REQ;
            end
            ST_RD_REQ: begin
                memreq_val = 1'b1;
                if (memreq_rdy) state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                memresp_rdy = 1'b1;
                if (memresp_val) state_next = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                memreq_val = 1'b1;
                if (memreq_rdy) state_next = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                memresp_rdy = 1'b1;
                if (memresp_val) state_next = (idx_inc == nwords) ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE: begin
                done_val = 1'b1;
                if (done_rdy) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command latch, read-data buffer, word index and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            src_addr <= '0;
            dst_addr <= '0;
            nwords   <= '0;
            domain   <= 1'b0;
            idx      <= '0;
            err      <= 1'b0;
            data_buf <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_val) begin
                        src_addr <= cmd_src;
                        dst_addr <= cmd_dst;
                        nwords   <= cmd_nwords;
                        domain   <= cmd_domain;
                        idx      <= '0;
                        err      <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    if (memresp_val) begin
                        data_buf <= memresp_data;
                        if (resp_type != c_mem_type_read) err <= 1'b1;
                    end
                end
                ST_WR_WAIT: begin
                    if (memresp_val) begin
                        idx <= idx_inc;
                        if (resp_type != c_mem_type_write) err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    a_inputs_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({memreq_rdy, memresp_val, cmd_val, done_rdy}));

    a_resp_in_wait: assert property (@(posedge clk) disable iff (reset)
        memresp_val |-> memresp_rdy);

endmodule
